// File: rtl/tlut_simd_mac.sv
// tlut_simd_mac: temporal-LUT SIMD MAC; clk/rst, start/acc_clear/input_bin/weight_bin in, ready/busy/done/product_acc out
module tlut_simd_mac #(
  parameter int LANES = 9,
  parameter int INPUT_WIDTH = 4,
  parameter int WEIGHT_WIDTH = 8,
  parameter int ACC_WIDTH = 16,
  parameter int EARLY_EXIT = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          acc_clear,
  input  logic [LANES*INPUT_WIDTH-1:0]  input_bin,
  input  logic [LANES*WEIGHT_WIDTH-1:0] weight_bin,
  output logic                          ready,
  output logic                          busy,
  output logic                          done,
  output logic [LANES*ACC_WIDTH-1:0]    product_acc
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t r_state, w_next;
  logic [INPUT_WIDTH-1:0] r_cnt, r_n, w_max, w_n;
  logic [LANES*INPUT_WIDTH-1:0] r_in;
  logic [LANES*WEIGHT_WIDTH-1:0] r_w;
  logic w_accept, w_last;
  assign w_accept = start && r_state == IDLE;
  assign w_last = r_cnt == r_n;
  always_comb begin
    w_max = '0;
    for (int i = 0; i < LANES; i++)
      w_max = input_bin[i*INPUT_WIDTH +: INPUT_WIDTH] > w_max ? input_bin[i*INPUT_WIDTH +: INPUT_WIDTH] : w_max;
  end
  assign w_n = EARLY_EXIT != 0 ? (w_max == '0 ? INPUT_WIDTH'(1) : w_max) : '1;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (start) w_next = RUN;
      RUN: if (w_last) w_next = DONE;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state <= IDLE;
      r_cnt <= '0;
      r_n <= '0;
      r_in <= '0;
      r_w <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_in <= input_bin;
        r_w <= weight_bin;
        r_n <= w_n;
        r_cnt <= '0;
      end else if (r_state == RUN) r_cnt <= r_cnt + 1'b1;
    end
  // RUN holds one extra slot with r_cnt == r_n; no lane can add there, so busy drops while sums settle
  assign ready = r_state == IDLE;
  assign busy = r_state == RUN && !w_last;
  assign done = r_state == DONE;
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [ACC_WIDTH-1:0] r_acc;
    logic w_add;
    assign w_add = r_state == RUN && r_cnt < r_in[l*INPUT_WIDTH +: INPUT_WIDTH];
    always_ff @(posedge clk or posedge rst)
      if (rst) r_acc <= '0;
      else if (w_accept && acc_clear) r_acc <= '0;
      else if (w_add) r_acc <= r_acc + ACC_WIDTH'($signed(r_w[l*WEIGHT_WIDTH +: WEIGHT_WIDTH]));
    assign product_acc[l*ACC_WIDTH +: ACC_WIDTH] = r_acc;
  end
endmodule

// File: tb/tb_tlut_simd_mac.sv
// tb_tlut_simd_mac: directed self-checking bench for tlut_simd_mac
module tb_tlut_simd_mac;
  logic clk = 1'b0;
  logic rst, start_a, start_b, clear;
  logic [11:0] in_bin;
  logic [23:0] w_bin;
  logic a_ready, a_busy, a_done, b_ready, b_busy, b_done;
  logic [47:0] a_acc;
  logic [35:0] b_acc;
  int n_vec = 0;
  int n_err = 0;
  always #5 clk = ~clk;
  tlut_simd_mac #(.LANES(3), .EARLY_EXIT(1)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .acc_clear(clear), .input_bin(in_bin), .weight_bin(w_bin),
    .ready(a_ready), .busy(a_busy), .done(a_done), .product_acc(a_acc));
  tlut_simd_mac #(.LANES(3), .ACC_WIDTH(12), .EARLY_EXIT(0)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .acc_clear(clear), .input_bin(in_bin), .weight_bin(w_bin),
    .ready(b_ready), .busy(b_busy), .done(b_done), .product_acc(b_acc));
  function automatic int lane(input int sel, input int i);
    logic signed [15:0] a;
    logic signed [11:0] b;
    a = a_acc[i*16 +: 16];
    b = b_acc[i*12 +: 12];
    return sel == 0 ? int'(a) : int'(b);
  endfunction
  function automatic int rdy(input int sel);
    return sel == 0 ? int'(a_ready) : int'(b_ready);
  endfunction
  function automatic int bsy(input int sel);
    return sel == 0 ? int'(a_busy) : int'(b_busy);
  endfunction
  function automatic int dne(input int sel);
    return sel == 0 ? int'(a_done) : int'(b_done);
  endfunction
  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic chk3(input string tag, input int sel, input int e0, input int e1, input int e2);
    chk({tag, "_l0"}, lane(sel, 0), e0);
    chk({tag, "_l1"}, lane(sel, 1), e1);
    chk({tag, "_l2"}, lane(sel, 2), e2);
  endtask
  task automatic pass(input int sel, input logic clr, input logic [11:0] ib, input logic [23:0] wb,
                      input int n, input string tag);
    int dk, bc;
    dk = 0;
    bc = 0;
    @(negedge clk);
    clear = clr;
    in_bin = ib;
    w_bin = wb;
    if (sel == 0) start_a = 1'b1;
    else start_b = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
    clear = ~clr;
    in_bin = ~ib;
    w_bin = ~wb;
    chk({tag, "_ready_lo"}, rdy(sel), 0);
    for (int k = 0; k < 40 && dk == 0; k++) begin
      if (k > 0) @(negedge clk);
      bc += bsy(sel);
      if (dne(sel) == 1) dk = k;
    end
    chk({tag, "_done_edge"}, dk, n + 1);
    chk({tag, "_busy_cycles"}, bc, n);
    @(negedge clk);
    chk({tag, "_done_pulse"}, dne(sel), 0);
    chk({tag, "_ready_hi"}, rdy(sel), 1);
  endtask
  initial begin
    int dones, prev_done, seen;
    rst = 1'b1;
    start_a = 1'b0;
    start_b = 1'b0;
    clear = 1'b0;
    in_bin = '0;
    w_bin = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", a_ready, 1);
    chk("rst_busy", a_busy, 0);
    chk("rst_done", a_done, 0);
    chk3("rst_a", 0, 0, 0, 0);
    chk3("rst_b", 1, 0, 0, 0);
    pass(0, 1'b1, 12'hA98, 24'h0A0908, 10, "basic_a");
    chk3("basic_a", 0, 64, 81, 100);
    pass(0, 1'b0, 12'hA98, 24'h0A0908, 10, "accum_a");
    chk3("accum_a", 0, 128, 162, 200);
    pass(0, 1'b1, 12'hF01, 24'hFD0705, 15, "signed_a");
    chk3("signed_a", 0, 5, 0, -45);
    pass(0, 1'b0, 12'h000, 24'h7F80FF, 1, "zero_keep");
    chk3("zero_keep", 0, 5, 0, -45);
    pass(0, 1'b1, 12'h000, 24'h7F80FF, 1, "zero_clr");
    chk3("zero_clr", 0, 0, 0, 0);
    pass(1, 1'b1, 12'hA98, 24'h0A0908, 15, "basic_b");
    chk3("basic_b", 1, 64, 81, 100);
    pass(1, 1'b1, 12'h18F, 24'h7F0980, 15, "wrap1");
    chk3("wrap1", 1, -1920, 72, 127);
    pass(1, 1'b0, 12'h18F, 24'h7F0980, 15, "wrap2");
    chk3("wrap2", 1, 256, 144, 254);
    pass(1, 1'b0, 12'h18F, 24'h7F0980, 15, "wrap3");
    chk3("wrap3", 1, -1664, 216, 381);
    @(negedge clk);
    clear = 1'b1;
    in_bin = 12'h012;
    w_bin = 24'h030303;
    start_a = 1'b1;
    dones = 0;
    prev_done = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (a_ready) begin
        in_bin = 12'h012;
        w_bin = 24'h030303;
      end else begin
        in_bin = 12'($urandom);
        w_bin = 24'($urandom);
      end
      if (a_done) begin
        dones++;
        chk("abuse_single_pulse", prev_done, 0);
        chk3("abuse", 0, 6, 3, 0);
      end
      prev_done = a_done;
    end
    start_a = 1'b0;
    chk("abuse_pass_count", dones, 6);
    @(negedge clk);
    clear = 1'b0;
    in_bin = 12'hA98;
    w_bin = 24'h0A0908;
    start_a = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_a = 1'b0;
    repeat (3) @(negedge clk);
    chk("midrun_busy", a_busy, 1);
    #2 rst = 1'b1;
    #1;
    chk3("midrun_rst_a", 0, 0, 0, 0);
    chk3("midrun_rst_b", 1, 0, 0, 0);
    chk("midrun_ready", a_ready, 1);
    chk("midrun_busy_lo", a_busy, 0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (a_done) seen = 1;
    end
    chk("midrun_no_done", seen, 0);
    pass(0, 1'b0, 12'hA98, 24'h0A0908, 10, "after_rst");
    chk3("after_rst", 0, 64, 81, 100);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
